fetch_icache_arbiter: RTL and testbench
=======================================

// Module: fetch_icache_arbiter
// PURPOSE
//  Shares the single synchronous port of the 4096x32 instruction memory among
//  two fetch requesters (slot 0 and slot 1) and a program loader (write-only).
//  - Loader writes always take priority.
//  - The two fetch slots alternate round-robin.
//  - Each fetch slot has one read in flight and a one-deep response register
//    with valid/ready backpressure.
//  - Sits between the fetch stage and the icache storage array.
// PARAMETERS
//  ADDR_W  12  word-index width of icache (depth = 2**ADDR_W)
//  DATA_W  32  instruction word width
//  PC_W    64  fetch address width; low ADDR_W bits index the array directly
// PORTS
//  clk           in   1       clock, all state updates on posedge
//  reset         in   1       asynchronous, active-high reset
//  req0_valid    in   1       slot 0 fetch request
//  req0_pc       in   PC_W    slot 0 fetch address
//  req0_ready    out  1       slot 0 request accepted this cycle
//  rsp0_valid    out  1       slot 0 response data valid
//  rsp0_data     out  DATA_W  slot 0 instruction word
//  rsp0_ready    in   1       slot 0 consumer takes the response
//  req1_*/rsp1_* (same six signals as slot 0)  slot 1
//  ld_valid      in   1       loader write request
//  ld_addr       in   ADDR_W  loader word index
//  ld_data       in   DATA_W  loader write data
//  ld_ready      out  1       loader write accepted (= ld_valid)
//  mem_en        out  1       array access strobe
//  mem_we        out  1       array write enable
//  mem_addr      out  ADDR_W  array word index
//  mem_wdata     out  DATA_W  array write data
//  mem_rdata     in   DATA_W  array read data, valid the cycle after mem_en & ~mem_we
// BEHAVIOUR
//  Per-slot FSM i:
//   IDLE: buffer empty, nothing pending.
//   WAIT: read issued last cycle.
//   HOLD: rsp_valid_i = 1.
//  Transitions:
//   IDLE -> WAIT on accept.
//   WAIT -> HOLD always; rsp_data_i <= mem_rdata at the end of WAIT.
//   HOLD & rsp_ready_i & accept -> WAIT.
//   HOLD & rsp_ready_i & ~accept -> IDLE.
//   HOLD otherwise: stay, rsp_data_i held stable.
//  can_i = (state==IDLE) | (state==HOLD & rsp_ready_i).
//  Arbitration, combinational, each cycle:
//   - ld_valid: loader granted; ld_ready=1; no fetch grant.
//   - else cand_i = req_valid_i & can_i.
//   - Single candidate: grant it.
//   - Both candidates: grant the slot != last_grant.
//   - last_grant updates only on fetch grants.
//  req_ready_i = grant_i; accept_i = grant_i (valid is already in cand).
//  Memory drive:
//   mem_en = any grant; mem_we = loader grant.
//   mem_addr = ld_addr or req_pc_i[ADDR_W-1:0] (upper PC bits ignored; wraps).
//   mem_wdata = ld_data.
//   All mem_* outputs and ready outputs are 0 when nothing is granted.
//  Latency and throughput:
//   - Accept in cycle N -> rsp_valid_i from cycle N+2.
//   - Per-slot throughput is 1 per 2 cycles.
//   - Two slots interleaved give 1 access per cycle.
//  Loader starvation: a sustained loader write stream blocks fetch indefinitely
//  (intended: boot/patch only).
//  Write/read order: a loader write in cycle N+1 does not affect data returned
//  for a read accepted in cycle N (old data).
//  Reset (async):
//   - Both slots -> IDLE; rsp_valid 0, rsp_data 0.
//   - last_grant = 1 (slot 0 wins first tie).
//   - In-flight reads are dropped; no response is produced after release.
// TESTING
//  1. mem[0x014]=0xDEADBEEF; req0 pc=0x0000_0000_0000_0014 at cycle 0
//     -> req0_ready=1, mem_addr=0x014 in cycle 0;
//     rsp0_valid=1, rsp0_data=0xDEADBEEF in cycle 2.
//  2. req0_valid=req1_valid=1 continuously, rsp*_ready=1
//     -> grants 0,1,0,1...; mem_en=1 every cycle; each slot gets rsp every 2 cycles.
//  3. ld_valid with ld_addr=0xFFF, ld_data=0x12345678, both fetch slots valid
//     -> ld_ready=1, mem_we=1, req*_ready=0.
//     Then req0 pc=0x1FFF -> mem_addr=0xFFF, rsp0_data=0x12345678.
//  4. rsp0 held with rsp0_ready=0 for 5 cycles
//     -> rsp0_data stable, req0_ready=0, slot 1 receives every grant.
//     Raise rsp0_ready -> slot 0 is re-accepted in that same cycle.
//  5. Assert reset mid-cycle while slot 0 is in WAIT
//     -> rsp0_valid=0 immediately.
//     After release: no rsp0_valid until a new accept; first tie goes to slot 0.

Source files
------------

// File: rtl/fetch_icache_arbiter.sv
// rtl/fetch_icache_arbiter.sv - shares one icache port among two fetch slots and a loader
// Loader writes win outright; fetch slots alternate on ties and each buffers one response.
module fetch_icache_arbiter #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32,
  parameter int PC_W   = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0_valid,
  input  logic [PC_W-1:0]   req0_pc,
  output logic              req0_ready,
  output logic              rsp0_valid,
  output logic [DATA_W-1:0] rsp0_data,
  input  logic              rsp0_ready,
  input  logic              req1_valid,
  input  logic [PC_W-1:0]   req1_pc,
  output logic              req1_ready,
  output logic              rsp1_valid,
  output logic [DATA_W-1:0] rsp1_data,
  input  logic              rsp1_ready,
  input  logic              ld_valid,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  output logic              ld_ready,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } slot_state_t;

  slot_state_t       r_state0;
  slot_state_t       r_state1;
  slot_state_t       w_state0_nxt;
  slot_state_t       w_state1_nxt;
  logic [DATA_W-1:0] r_rsp0_data;
  logic [DATA_W-1:0] r_rsp1_data;
  logic              r_last_grant;
  logic              w_last_grant_nxt;
  logic              w_can0;
  logic              w_can1;
  logic              w_cand0;
  logic              w_cand1;
  logic              w_grant0;
  logic              w_grant1;
  logic              w_unused_pc;

  // Only the low ADDR_W bits of a PC index the array; the rest wrap away.
  assign w_unused_pc = ^{req0_pc[PC_W-1:ADDR_W], req1_pc[PC_W-1:ADDR_W]};

  function automatic slot_state_t slot_next(input slot_state_t cur,
                                            input logic        rsp_ready,
                                            input logic        accept);
    slot_state_t nxt;
    nxt = cur;
    case (cur)
      S_IDLE: if (accept) nxt = S_WAIT;
      S_WAIT: nxt = S_HOLD;
      S_HOLD: begin
        if (rsp_ready) nxt = accept ? S_WAIT : S_IDLE;
      end
      default: nxt = S_IDLE;
    endcase
    return nxt;
  endfunction

  always_comb begin
    w_can0           = 1'b0;
    w_can1           = 1'b0;
    w_cand0          = 1'b0;
    w_cand1          = 1'b0;
    w_grant0         = 1'b0;
    w_grant1         = 1'b0;
    w_last_grant_nxt = r_last_grant;
    w_state0_nxt     = r_state0;
    w_state1_nxt     = r_state1;

    // A slot can take a new read if its buffer is empty or drains this cycle.
    w_can0  = (r_state0 == S_IDLE) | ((r_state0 == S_HOLD) & rsp0_ready);
    w_can1  = (r_state1 == S_IDLE) | ((r_state1 == S_HOLD) & rsp1_ready);
    w_cand0 = ~ld_valid & req0_valid & w_can0;
    w_cand1 = ~ld_valid & req1_valid & w_can1;

    w_grant0 = w_cand0 & (~w_cand1 | r_last_grant);
    w_grant1 = w_cand1 & (~w_cand0 | ~r_last_grant);

    if (w_grant0) w_last_grant_nxt = 1'b0;
    else if (w_grant1) w_last_grant_nxt = 1'b1;

    w_state0_nxt = slot_next(r_state0, rsp0_ready, w_grant0);
    w_state1_nxt = slot_next(r_state1, rsp1_ready, w_grant1);
  end

  always_comb begin
    req0_ready = w_grant0;
    req1_ready = w_grant1;
    ld_ready   = ld_valid;
    mem_en     = ld_valid | w_grant0 | w_grant1;
    mem_we     = ld_valid;
    mem_addr   = '0;
    mem_wdata  = '0;
    if (ld_valid) begin
      mem_addr  = ld_addr;
      mem_wdata = ld_data;
    end else if (w_grant0) begin
      mem_addr = req0_pc[ADDR_W-1:0];
    end else if (w_grant1) begin
      mem_addr = req1_pc[ADDR_W-1:0];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state0     <= S_IDLE;
      r_state1     <= S_IDLE;
      r_rsp0_data  <= '0;
      r_rsp1_data  <= '0;
      r_last_grant <= 1'b1;
    end else begin
      r_state0     <= w_state0_nxt;
      r_state1     <= w_state1_nxt;
      r_last_grant <= w_last_grant_nxt;
      // Read data arrives the cycle after issue, i.e. while the slot sits in WAIT.
      if (r_state0 == S_WAIT) r_rsp0_data <= mem_rdata;
      if (r_state1 == S_WAIT) r_rsp1_data <= mem_rdata;
    end
  end

  assign rsp0_valid = (r_state0 == S_HOLD);
  assign rsp1_valid = (r_state1 == S_HOLD);
  assign rsp0_data  = r_rsp0_data;
  assign rsp1_data  = r_rsp1_data;

endmodule

// File: tb/tb_fetch_icache_arbiter.sv
// tb/tb_fetch_icache_arbiter.sv - vector table and response scoreboard for fetch_icache_arbiter
module tb_fetch_icache_arbiter;

  logic        clk;
  logic        reset;
  logic        req0_valid, req1_valid, rsp0_ready, rsp1_ready, ld_valid;
  logic [63:0] req0_pc, req1_pc;
  logic        req0_ready, req1_ready, rsp0_valid, rsp1_valid, ld_ready;
  logic [31:0] rsp0_data, rsp1_data, ld_data, mem_wdata, mem_rdata;
  logic [11:0] ld_addr, mem_addr;
  logic        mem_en, mem_we;

  fetch_icache_arbiter #(.ADDR_W(12), .DATA_W(32), .PC_W(64)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_pc(req0_pc), .req0_ready(req0_ready),
    .rsp0_valid(rsp0_valid), .rsp0_data(rsp0_data), .rsp0_ready(rsp0_ready),
    .req1_valid(req1_valid), .req1_pc(req1_pc), .req1_ready(req1_ready),
    .rsp1_valid(rsp1_valid), .rsp1_data(rsp1_data), .rsp1_ready(rsp1_ready),
    .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_data(ld_data), .ld_ready(ld_ready),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(input logic [11:0] a);
    return (a == 12'h014) ? 32'hDEADBEEF : {16'hC0DE, 4'h0, a};
  endfunction

  // Synchronous 4096x32 array driven by the DUT
  logic [31:0] tb_mem  [0:4095];
  bit          written [0:4095];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) begin
        tb_mem[mem_addr]  <= mem_wdata;
        written[mem_addr] <= 1'b1;
      end else begin
        mem_rdata <= written[mem_addr] ? tb_mem[mem_addr] : init_word(mem_addr);
      end
    end
  end

  typedef struct packed {
    logic        ldv;
    logic [11:0] lda;
    logic [31:0] ldd;
    logic        r0v;
    logic [63:0] r0pc;
    logic        r1v;
    logic [63:0] r1pc;
    logic        k0;
    logic        k1;
    logic        e_g0;
    logic        e_g1;
    logic        e_ldr;
    logic        e_en;
    logic        e_we;
    logic [11:0] e_addr;
    logic        e_v0;
    logic        e_v1;
  } vec_t;

  function automatic vec_t mk(
    input logic ldv, input logic [11:0] lda, input logic [31:0] ldd,
    input logic r0v, input logic [63:0] r0pc, input logic r1v, input logic [63:0] r1pc,
    input logic k0, input logic k1,
    input logic g0, input logic g1, input logic ldr, input logic en, input logic we,
    input logic [11:0] addr, input logic v0, input logic v1);
    vec_t v;
    v.ldv = ldv; v.lda = lda; v.ldd = ldd;
    v.r0v = r0v; v.r0pc = r0pc; v.r1v = r1v; v.r1pc = r1pc;
    v.k0 = k0; v.k1 = k1;
    v.e_g0 = g0; v.e_g1 = g1; v.e_ldr = ldr; v.e_en = en; v.e_we = we;
    v.e_addr = addr; v.e_v0 = v0; v.e_v1 = v1;
    return v;
  endfunction

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] exp_mem [0:4095];
  logic [31:0] q0 [$];
  logic [31:0] q1 [$];
  vec_t        tbl [$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: response valid with nothing outstanding", name);
  endtask

  task automatic drive_idle();
    ld_valid = 0; ld_addr = '0; ld_data = '0;
    req0_valid = 0; req0_pc = '0; req1_valid = 0; req1_pc = '0;
    rsp0_ready = 1; rsp1_ready = 1;
  endtask

  task automatic apply_vec(input vec_t v, input string tag);
    @(posedge clk);
    #1;
    ld_valid = v.ldv; ld_addr = v.lda; ld_data = v.ldd;
    req0_valid = v.r0v; req0_pc = v.r0pc; req1_valid = v.r1v; req1_pc = v.r1pc;
    rsp0_ready = v.k0; rsp1_ready = v.k1;
    @(negedge clk);
    check({tag, ".req0_ready"}, 64'(req0_ready), 64'(v.e_g0));
    check({tag, ".req1_ready"}, 64'(req1_ready), 64'(v.e_g1));
    check({tag, ".ld_ready"},   64'(ld_ready),   64'(v.e_ldr));
    check({tag, ".mem_en"},     64'(mem_en),     64'(v.e_en));
    check({tag, ".mem_we"},     64'(mem_we),     64'(v.e_we));
    check({tag, ".mem_addr"},   64'(mem_addr),   64'(v.e_addr));
    check({tag, ".rsp0_valid"}, 64'(rsp0_valid), 64'(v.e_v0));
    check({tag, ".rsp1_valid"}, 64'(rsp1_valid), 64'(v.e_v1));
    if (v.e_we) check({tag, ".mem_wdata"}, 64'(mem_wdata), 64'(v.ldd));
    // Held responses are compared every cycle, so a changing buffer is caught too
    if (rsp0_valid) begin
      if (q0.size() == 0) unexpected({tag, ".rsp0"});
      else begin
        check({tag, ".rsp0_data"}, 64'(rsp0_data), 64'(q0[0]));
        if (v.k0) void'(q0.pop_front());
      end
    end
    if (rsp1_valid) begin
      if (q1.size() == 0) unexpected({tag, ".rsp1"});
      else begin
        check({tag, ".rsp1_data"}, 64'(rsp1_data), 64'(q1[0]));
        if (v.k1) void'(q1.pop_front());
      end
    end
    if (v.e_g0) q0.push_back(exp_mem[v.r0pc[11:0]]);
    if (v.e_g1) q1.push_back(exp_mem[v.r1pc[11:0]]);
    if (v.e_we) exp_mem[v.lda] = v.ldd;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int a = 0; a < 4096; a++) exp_mem[a] = init_word(12'(a));

    //            ldv lda     ldd           r0v r0pc                     r1v r1pc                     k0 k1  g0 g1 ldr en we addr     v0 v1
    tbl.push_back(mk(0, 12'h0,   32'h0,        0, 64'h0,                    0, 64'h0,                    0, 0,  0, 0, 0, 0, 0, 12'h000, 0, 0));
    tbl.push_back(mk(0, 12'h0,   32'h0,        1, 64'h14,                   0, 64'h0,                    1, 0,  1, 0, 0, 1, 0, 12'h014, 0, 0));
    tbl.push_back(mk(0, 12'h0,   32'h0,        0, 64'h0,                    0, 64'h0,                    1, 1,  0, 0, 0, 0, 0, 12'h000, 0, 0));
    tbl.push_back(mk(0, 12'h0,   32'h0,        0, 64'h0,                    0, 64'h0,                    1, 1,  0, 0, 0, 0, 0, 12'h000, 1, 0));
    tbl.push_back(mk(0, 12'h0,   32'h0,        1, 64'h200,                  1, 64'h100,                  1, 1,  0, 1, 0, 1, 0, 12'h100, 0, 0));
    tbl.push_back(mk(0, 12'h0,   32'h0,        1, 64'h201,                  1, 64'h101,                  1, 1,  1, 0, 0, 1, 0, 12'h201, 0, 0));
    tbl.push_back(mk(0, 12'h0,   32'h0,        1, 64'h202,                  1, 64'hFFFF_0000_0000_0102,  1, 1,  0, 1, 0, 1, 0, 12'h102, 0, 1));
    tbl.push_back(mk(0, 12'h0,   32'h0,        1, 64'h8000_0000_0000_0203,  1, 64'h103,                  1, 1,  1, 0, 0, 1, 0, 12'h203, 1, 0));
    tbl.push_back(mk(0, 12'h0,   32'h0,        1, 64'h204,                  1, 64'h104,                  1, 1,  0, 1, 0, 1, 0, 12'h104, 0, 1));
    tbl.push_back(mk(0, 12'h0,   32'h0,        1, 64'h205,                  1, 64'h105,                  1, 1,  1, 0, 0, 1, 0, 12'h205, 1, 0));
    tbl.push_back(mk(1, 12'hFFF, 32'h12345678, 1, 64'h206,                  1, 64'h106,                  1, 1,  0, 0, 1, 1, 1, 12'hFFF, 0, 1));
    tbl.push_back(mk(0, 12'h0,   32'h0,        1, 64'h1FFF,                 0, 64'h0,                    1, 1,  1, 0, 0, 1, 0, 12'hFFF, 1, 0));
    tbl.push_back(mk(0, 12'h0,   32'h0,        0, 64'h0,                    0, 64'h0,                    1, 1,  0, 0, 0, 0, 0, 12'h000, 0, 0));
    tbl.push_back(mk(0, 12'h0,   32'h0,        1, 64'h300,                  1, 64'h110,                  0, 1,  0, 1, 0, 1, 0, 12'h110, 1, 0));
    tbl.push_back(mk(0, 12'h0,   32'h0,        1, 64'h300,                  1, 64'h111,                  0, 1,  0, 0, 0, 0, 0, 12'h000, 1, 0));
    tbl.push_back(mk(0, 12'h0,   32'h0,        1, 64'h300,                  1, 64'h112,                  0, 1,  0, 1, 0, 1, 0, 12'h112, 1, 1));
    tbl.push_back(mk(0, 12'h0,   32'h0,        1, 64'h300,                  1, 64'h113,                  0, 1,  0, 0, 0, 0, 0, 12'h000, 1, 0));
    tbl.push_back(mk(0, 12'h0,   32'h0,        1, 64'h300,                  1, 64'h114,                  0, 1,  0, 1, 0, 1, 0, 12'h114, 1, 1));
    tbl.push_back(mk(0, 12'h0,   32'h0,        1, 64'h300,                  1, 64'h115,                  1, 1,  1, 0, 0, 1, 0, 12'h300, 1, 0));
    tbl.push_back(mk(0, 12'h0,   32'h0,        0, 64'h0,                    0, 64'h0,                    1, 1,  0, 0, 0, 0, 0, 12'h000, 0, 1));
    tbl.push_back(mk(0, 12'h0,   32'h0,        0, 64'h0,                    0, 64'h0,                    1, 1,  0, 0, 0, 0, 0, 12'h000, 1, 0));

    reset = 1'b1;
    drive_idle();
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    check("reset.rsp0_valid", 64'(rsp0_valid), 64'h0);
    check("reset.rsp1_valid", 64'(rsp1_valid), 64'h0);
    check("reset.rsp0_data",  64'(rsp0_data),  64'h0);
    check("reset.rsp1_data",  64'(rsp1_data),  64'h0);
    check("reset.mem_en",     64'(mem_en),     64'h0);
    @(posedge clk);
    #1 reset = 1'b0;

    for (int i = 0; i < tbl.size(); i++) apply_vec(tbl[i], $sformatf("vec%0d", i));

    // Slot 1 holding (unready) and slot 0 in WAIT when reset hits mid-cycle
    apply_vec(mk(0, 12'h0, 32'h0, 0, 64'h0,  1, 64'h40, 1, 0,  0, 1, 0, 1, 0, 12'h040, 0, 0), "rst_pre0");
    apply_vec(mk(0, 12'h0, 32'h0, 0, 64'h0,  0, 64'h0,  1, 0,  0, 0, 0, 0, 0, 12'h000, 0, 0), "rst_pre1");
    apply_vec(mk(0, 12'h0, 32'h0, 1, 64'h30, 0, 64'h0,  1, 0,  1, 0, 0, 1, 0, 12'h030, 0, 1), "rst_pre2");
    @(posedge clk);
    #1 drive_idle();
    #2 reset = 1'b1;
    #1;
    check("midreset.rsp0_valid", 64'(rsp0_valid), 64'h0);
    check("midreset.rsp1_valid", 64'(rsp1_valid), 64'h0);
    check("midreset.rsp1_data",  64'(rsp1_data),  64'h0);
    q0.delete();
    q1.delete();
    @(posedge clk);
    #1 reset = 1'b0;

    for (int i = 0; i < 3; i++)
      apply_vec(mk(0, 12'h0, 32'h0, 0, 64'h0, 0, 64'h0, 1, 1, 0, 0, 0, 0, 0, 12'h000, 0, 0),
                $sformatf("post_rst%0d", i));
    apply_vec(mk(0, 12'h0, 32'h0, 1, 64'h50, 1, 64'h60, 1, 1,  1, 0, 0, 1, 0, 12'h050, 0, 0), "tie0");
    apply_vec(mk(0, 12'h0, 32'h0, 0, 64'h0,  0, 64'h0,  1, 1,  0, 0, 0, 0, 0, 12'h000, 0, 0), "tie1");
    apply_vec(mk(0, 12'h0, 32'h0, 0, 64'h0,  0, 64'h0,  1, 1,  0, 0, 0, 0, 0, 12'h000, 1, 0), "tie2");

    check("drain.q0_left", 64'(q0.size()), 64'h0);
    check("drain.q1_left", 64'(q1.size()), 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
